// File: rtl/bpu_pkg.sv
// Shared types and constants for the two-bit branch prediction unit.
package bpu_pkg;

  // Default table geometry: 64 entries indexed by pc[7:2], tag = pc[31:8].
  localparam int BPU_INDEX_W = 6;
  localparam int BPU_TAG_W   = 32 - BPU_INDEX_W - 2;

  // Two-bit saturating direction counter; the MSB is the taken prediction.
  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  // One table entry, laid out for the default geometry.
  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    logic [31:0]          target;
    ctr_t                 ctr;
  } bpu_entry_t;

endpackage

// File: rtl/sat_ctr2.sv
// Next-state logic for a two-bit saturating counter.
module sat_ctr2
  import bpu_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_next_o
);

  // Step toward ST on taken and toward SNT on not-taken, holding at the ends.
  always_comb begin
    ctr_next_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_next_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_next_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/bpu_two_bit.sv
// Direct-mapped two-bit branch predictor: combinational IF lookup,
// EX-stage resolve/redirect, registered training and perf counters.
module bpu_two_bit
  import bpu_pkg::*;
#(
  parameter int INDEX_W = BPU_INDEX_W,
  parameter int TAG_W   = 32 - INDEX_W - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] pc_ex,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int ENTRIES = 1 << INDEX_W;

  // Valid bits and counters are reset; tag/target are only meaningful
  // behind a set valid bit, so they carry no reset.
  logic [ENTRIES-1:0] valid_q, valid_d;
  ctr_t               ctr_q [ENTRIES];
  ctr_t               ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0]   tag_if, tag_ex;
  logic               hit_if, hit_ex;
  logic               upd_fire;
  ctr_t               ctr_ex_next;
  bpu_entry_t         wr_entry;
  logic               wr_state, wr_target, wr_tag;

  assign idx_if = pc_if[INDEX_W+1:2];
  assign tag_if = pc_if[31:INDEX_W+2];
  assign idx_ex = pc_ex[INDEX_W+1:2];
  assign tag_ex = pc_ex[31:INDEX_W+2];

  // IF lookup reads the pre-update table contents; no bypass from EX.
  always_comb begin
    hit_if      = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    pred_taken  = hit_if && ctr_q[idx_if][1];
    pred_target = pred_taken ? target_q[idx_if] : (pc_if + 32'd4);
  end

  // EX resolve: redirect on wrong direction, or wrong target when taken.
  always_comb begin
    hit_ex     = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
    upd_fire   = upd_en && !rst;
    correct_pc = br_taken ? br_target : (pc_ex + 32'd4);
    mispredict = upd_fire &&
                 ((ex_pred_taken != br_taken) ||
                  (br_taken && (ex_pred_target != br_target)));
  end

  sat_ctr2 u_sat_ctr2 (
    .ctr_i      (ctr_q[idx_ex]),
    .taken_i    (br_taken),
    .ctr_next_o (ctr_ex_next)
  );

  // Build the entry image to write back: a hit trains the existing counter,
  // a taken miss allocates fresh at weakly-taken.
  always_comb begin
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = BPU_TAG_W'(tag_ex);
    wr_entry.target = br_target;
    wr_entry.ctr    = hit_ex ? ctr_ex_next : WT;
    wr_state        = upd_fire && (hit_ex || br_taken);
    wr_target       = upd_fire && br_taken;
    wr_tag          = upd_fire && br_taken && !hit_ex;
  end

  // Per-entry next state for valid and counter.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic sel;
    assign sel          = wr_state && (idx_ex == INDEX_W'(gi));
    assign valid_d[gi]  = sel ? wr_entry.valid : valid_q[gi];
    assign ctr_d[gi]    = sel ? wr_entry.ctr   : ctr_q[gi];
  end

  // Performance counters; both wrap naturally at 2^32.
  always_comb begin
    br_cnt_d      = br_cnt_q + 32'(upd_fire);
    mispred_cnt_d = mispred_cnt_q + 32'(mispredict);
  end

  // Reset-bearing state: valid bits, counters, perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag/target storage; writes are already suppressed during reset.
  always_ff @(posedge clk) begin
    if (wr_target) target_q[idx_ex] <= wr_entry.target;
    if (wr_tag)    tag_q[idx_ex]    <= TAG_W'(wr_entry.tag);
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bpu_two_bit.sv
// Testbench for bpu_two_bit: directed scenarios plus randomized traffic
// checked against a table model that tracks counters as bounded integers.
module tb_bpu_two_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] pc_ex;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_txn  = 0;

  always #5 clk = ~clk;

  bpu_two_bit dut (
    .clk(clk), .rst(rst), .pc_if(pc_if), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_en(upd_en), .pc_ex(pc_ex),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .br_taken(br_taken), .br_target(br_target), .mispredict(mispredict),
    .correct_pc(correct_pc), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  // Reference table: strength 0..3, taken predicted when strength >= 2.
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_str   [64];
  logic [31:0] m_br;
  logic [31:0] m_mis_cnt;

  function automatic int midx(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == pc[31:8]);
  endfunction

  function automatic logic m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_str[midx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
  endfunction

  function automatic logic m_mis();
    return upd_en && !rst &&
           ((ex_pred_taken != br_taken) || (br_taken && ex_pred_target != br_target));
  endfunction

  function automatic logic [31:0] m_correct();
    return br_taken ? br_target : pc_ex + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_str[i]   = 1;
    end
    m_br      = 0;
    m_mis_cnt = 0;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic tk,
                              input logic [31:0] tgt, input logic mis);
    int i;
    i = midx(pc);
    if (m_hit(pc)) begin
      if (tk) begin
        m_str[i] = (m_str[i] == 3) ? 3 : m_str[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_str[i] = (m_str[i] == 0) ? 0 : m_str[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1;
      m_tag[i]   = pc[31:8];
      m_tgt[i]   = tgt;
      m_str[i]   = 2;
    end
    m_br = m_br + 1;
    if (mis) m_mis_cnt = m_mis_cnt + 1;
  endtask

  // Present one cycle of inputs at the falling edge; outputs settle by #1.
  task automatic drive(input logic [31:0] pif, input logic u, input logic [31:0] pe,
                       input logic ept, input logic [31:0] eptt,
                       input logic bt, input logic [31:0] btt);
    @(negedge clk);
    pc_if = pif; upd_en = u; pc_ex = pe;
    ex_pred_taken = ept; ex_pred_target = eptt;
    br_taken = bt; br_target = btt;
    #1;
  endtask

  // Clock the presented cycle into DUT and model, then drop upd_en.
  task automatic commit();
    logic mis_now;
    @(posedge clk);
    mis_now = m_mis();
    if (rst) model_reset();
    else if (upd_en) model_update(pc_ex, br_taken, br_target, mis_now);
    if (upd_en || rst) begin
      n_txn++;
      $display("txn %0d rst=%0b upd=%0b pc_ex=%h taken=%0b tgt=%h mis=%0b",
               n_txn, rst, upd_en, pc_ex, br_taken, br_target, mis_now);
    end
    #1;
    upd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    commit();
    commit();
    rst = 1'b0;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target got %h want 00000104", pred_target); end
    n_cmp++; if (br_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_br_cnt got %0d want 0", br_cnt); end
    n_cmp++; if (mispred_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_mispred_cnt got %0d want 0", mispred_cnt); end
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict got %0b want 0", mispredict); end
  endtask

  task automatic test_alloc();
    drive(32'h0, 1'b1, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
    n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL alloc_mispredict got %0b want 1", mispredict); end
    n_cmp++; if (correct_pc !== 32'h80) begin n_fail++; $display("FAIL alloc_correct_pc got %h want 00000080", correct_pc); end
    commit();
    pc_if = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_pred_taken got %0b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h80) begin n_fail++; $display("FAIL alloc_pred_target got %h want 00000080", pred_target); end
    n_cmp++; if (br_cnt !== 32'd1) begin n_fail++; $display("FAIL alloc_br_cnt got %0d want 1", br_cnt); end
    n_cmp++; if (mispred_cnt !== 32'd1) begin n_fail++; $display("FAIL alloc_mispred_cnt got %0d want 1", mispred_cnt); end
  endtask

  // Entry 0x100 starts at WT. Each step: direction, expected prediction after.
  task automatic test_saturation();
    logic steps_tk  [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    logic steps_exp [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    for (int s = 0; s < 14; s++) begin
      drive(32'h100, 1'b1, 32'h100, m_pred_taken(32'h100), m_pred_target(32'h100),
            steps_tk[s], 32'h80);
      commit();
      pc_if = 32'h100; #1;
      n_cmp++;
      if (pred_taken !== steps_exp[s]) begin
        n_fail++;
        $display("FAIL sat_step%0d_pred_taken got %0b want %0b", s, pred_taken, steps_exp[s]);
      end
    end
  endtask

  task automatic test_alias();
    drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_miss_pred_taken got %0b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h204) begin n_fail++; $display("FAIL alias_miss_pred_target got %h want 00000204", pred_target); end
    drive(32'h100, 1'b1, 32'h200, 1'b0, 32'h204, 1'b0, 32'h0);
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL alias_nt_mispredict got %0b want 0", mispredict); end
    n_cmp++; if (correct_pc !== 32'h204) begin n_fail++; $display("FAIL alias_nt_correct_pc got %h want 00000204", correct_pc); end
    commit();
    pc_if = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin n_fail++; $display("FAIL alias_nt_unchanged got %0b/%h want 1/00000080", pred_taken, pred_target); end
    drive(32'h0, 1'b1, 32'h200, 1'b0, 32'h204, 1'b1, 32'h300);
    commit();
    pc_if = 32'h200; #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin n_fail++; $display("FAIL alias_replace got %0b/%h want 1/00000300", pred_taken, pred_target); end
    pc_if = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin n_fail++; $display("FAIL alias_evicted got %0b/%h want 0/00000104", pred_taken, pred_target); end
  endtask

  task automatic test_target_mismatch();
    drive(32'h0, 1'b1, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
    commit();
    drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h90);
    n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL tgt_mispredict got %0b want 1", mispredict); end
    n_cmp++; if (correct_pc !== 32'h90) begin n_fail++; $display("FAIL tgt_correct_pc got %h want 00000090", correct_pc); end
    commit();
    pc_if = 32'h100; #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin n_fail++; $display("FAIL tgt_retrained got %0b/%h want 1/00000090", pred_taken, pred_target); end
    drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL tgt_correct_mispredict got %0b want 0", mispredict); end
    commit();
    drive(32'h0, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL tgt_idle_mispredict got %0b want 0", mispredict); end
    n_cmp++; if (correct_pc !== 32'h104) begin n_fail++; $display("FAIL tgt_idle_correct_pc got %h want 00000104", correct_pc); end
    commit();
    n_cmp++; if (br_cnt !== m_br || mispred_cnt !== m_mis_cnt) begin n_fail++; $display("FAIL tgt_counters got %0d/%0d want %0d/%0d", br_cnt, mispred_cnt, m_br, m_mis_cnt); end
  endtask

  task automatic test_collision();
    drive(32'h140, 1'b1, 32'h140, 1'b0, 32'h144, 1'b1, 32'h44);
    n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin n_fail++; $display("FAIL coll_same_cycle got %0b/%h want 0/00000144", pred_taken, pred_target); end
    commit();
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h44) begin n_fail++; $display("FAIL coll_next_cycle got %0b/%h want 1/00000044", pred_taken, pred_target); end
    rst = 1'b1;
    drive(32'h180, 1'b1, 32'h180, 1'b0, 32'h184, 1'b1, 32'h99);
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL coll_rst_mispredict got %0b want 0", mispredict); end
    commit();
    rst = 1'b0;
    n_cmp++; if (br_cnt !== 32'h0 || mispred_cnt !== 32'h0) begin n_fail++; $display("FAIL coll_rst_counters got %0d/%0d want 0/0", br_cnt, mispred_cnt); end
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 64; i++) begin
        pc_if = (32'(t) << 8) | (32'(i) << 2); #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
          n_fail++;
          $display("FAIL coll_rst_invalid pc=%h got %0b want 0", pc_if, pred_taken);
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [23:0] tags [4] = '{24'h0, 24'h1, 24'h2, 24'hFFFFFF};
    logic [5:0]  idx;
    idx = ($urandom_range(0, 7) == 7) ? 6'd63 : 6'($urandom_range(0, 6));
    return {tags[$urandom_range(0, 3)], idx, 2'b00};
  endfunction

  task automatic test_random();
    logic [31:0] pe, pif, btt;
    logic        ept;
    logic [31:0] eptt;
    for (int it = 0; it < 400; it++) begin
      pif = rand_pc();
      pe  = rand_pc();
      ept  = ($urandom_range(0, 3) != 0) ? m_pred_taken(pe) : 1'($urandom_range(0, 1));
      eptt = ($urandom_range(0, 3) != 0) ? m_pred_target(pe) : 32'h1000;
      case ($urandom_range(0, 3))
        0: btt = 32'h80;
        1: btt = 32'h90;
        2: btt = 32'hFFFF_FFFC;
        default: btt = pe + 32'd8;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      drive(pif, 1'($urandom_range(0, 3) != 0), pe, ept, eptt, 1'($urandom_range(0, 1)), btt);
      n_cmp++; if (pred_taken !== m_pred_taken(pif)) begin n_fail++; $display("FAIL rnd%0d_pred_taken got %0b want %0b", it, pred_taken, m_pred_taken(pif)); end
      n_cmp++; if (pred_target !== m_pred_target(pif)) begin n_fail++; $display("FAIL rnd%0d_pred_target got %h want %h", it, pred_target, m_pred_target(pif)); end
      n_cmp++; if (mispredict !== m_mis()) begin n_fail++; $display("FAIL rnd%0d_mispredict got %0b want %0b", it, mispredict, m_mis()); end
      n_cmp++; if (correct_pc !== m_correct()) begin n_fail++; $display("FAIL rnd%0d_correct_pc got %h want %h", it, correct_pc, m_correct()); end
      commit();
      rst = 1'b0;
      n_cmp++; if (br_cnt !== m_br || mispred_cnt !== m_mis_cnt) begin n_fail++; $display("FAIL rnd%0d_counters got %0d/%0d want %0d/%0d", it, br_cnt, mispred_cnt, m_br, m_mis_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; pc_if = '0; upd_en = 1'b0; pc_ex = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0; br_taken = 1'b0; br_target = '0;
    model_reset();
    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_target_mismatch();
    test_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bpu_two_bit.md
Name: bpu_two_bit

Overview:
- Branch prediction unit for the pipelined RV32I core, two-bit milestone.
- Sits at the opposite end of the branch path from the EX-stage ALU. In IF it predicts direction and target for the fetch PC. In EX it consumes the ALU's resolved branch decision (br_sel) and target, trains its tables and raises mispredict/redirect.
- Direct-mapped table; each entry holds a tag, a target and a 2-bit saturating counter.
- Also keeps performance counters for resolved branches and mispredictions.

Parameters:
- INDEX_W, 6, log2 of table entries (64 entries); index = pc[INDEX_W+1:2].
- TAG_W, 32-INDEX_W-2, tag width; tag = pc[31:INDEX_W+2].

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_if  in  32  fetch-stage PC being looked up
- pred_taken  out  1  IF prediction: taken
- pred_target  out  32  IF next-PC prediction
- upd_en  in  1  EX stage holds a branch/jump this cycle (ALU branch input)
- pc_ex  in  32  PC of the EX-stage instruction
- ex_pred_taken  in  1  prediction carried down the pipe with that instruction
- ex_pred_target  in  32  predicted target carried down the pipe
- br_taken  in  1  resolved direction (ALU br_sel)
- br_target  in  32  resolved target (ALU alu_data)
- mispredict  out  1  flush/redirect request
- correct_pc  out  32  redirect PC
- br_cnt  out  32  resolved branches since reset
- mispred_cnt  out  32  mispredictions since reset

Behaviour:
Lookup (combinational, zero latency):
- hit = valid[idx] && tag[idx] == pc_if tag.
- pred_taken = hit && ctr[idx][1].
- pred_target = pred_taken ? target[idx] : pc_if + 4 (32-bit wrap).

Resolve (combinational, EX):
- correct_pc = br_taken ? br_target : pc_ex + 4.
- mispredict = upd_en && ((ex_pred_taken != br_taken) || (br_taken && ex_pred_target != br_target)).
- mispredict is 0 whenever upd_en = 0 or rst = 1.

Update (registered, effective next cycle; only when upd_en && !rst):
- Counter encoding: SNT = 00, WNT = 01, WT = 10, ST = 11.
- Hit, taken: ctr saturating increment (ST stays ST); target <= br_target.
- Hit, not taken: ctr saturating decrement (SNT stays SNT); target unchanged.
- Miss, taken: allocate/replace the entry. valid <= 1, tag <= pc_ex tag, target <= br_target, ctr <= WT.
- Miss, not taken: no allocation; table unchanged.
- Performance counters: br_cnt += 1 on every update; mispred_cnt += 1 when mispredict. Both wrap modulo 2^32.

Boundary conditions:
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. No bypass. The new contents are visible from the next cycle.
- JAL/JALR arrive as br_taken = 1 and train like taken branches.
- Reset, completing in one clock: all valid <= 0, all ctr <= WNT, br_cnt = mispred_cnt = 0. Tag and target arrays need no reset.
- Reset mid-operation: an update presented in the same cycle as rst is discarded.
- Output values after reset: pred_taken = 0, pred_target = pc_if + 4, mispredict = 0, counters = 0.

Decomposition:
- Package bpu_pkg:
  - ctr_t (2-bit counter type) and the SNT/WNT/WT/ST constants.
  - bpu_entry_t struct {valid, tag, target, ctr}.
  - Default INDEX_W.
- Sub-module sat_ctr2: combinational next-state for the 2-bit saturating counter; inputs ctr, taken; output next ctr.

Test Plan:
1. Cold lookup: reset, release, pc_if = 0x100 -> pred_taken = 0, pred_target = 0x104, br_cnt = 0, mispred_cnt = 0.
2. Allocation on taken miss:
   - Stimulus: upd_en, pc_ex = 0x100, br_taken = 1, br_target = 0x80, ex_pred_taken = 0.
   - Same cycle: mispredict = 1, correct_pc = 0x80.
   - Next cycle: pc_if = 0x100 gives pred_taken = 1, pred_target = 0x80; br_cnt = 1, mispred_cnt = 1.
3. Counter saturation at entry 0x100:
   - From WT: two not-taken updates take ctr WT -> WNT -> SNT; pred_taken = 0 after the first.
   - A third not-taken update holds SNT.
   - One taken update moves to WNT; pred_taken stays 0.
   - Separately, three taken updates from WT saturate at ST.
4. Aliasing (INDEX_W = 6):
   - 0x100 and 0x200 share index 0 with different tags. With 0x100 allocated, lookup of 0x200 -> pred_taken = 0, pred_target = 0x204.
   - Taken update of 0x200 to 0x300 replaces the entry; 0x100 now misses.
   - A not-taken update of 0x200 on a miss leaves the table unchanged.
5. Target mismatch: hit with ex_pred_taken = 1, ex_pred_target = 0x80, br_taken = 1, br_target = 0x90 -> mispredict = 1, correct_pc = 0x90; next lookup target = 0x90.
6. Same-cycle and reset collisions:
   - Lookup and update of the same PC in one cycle: lookup returns the old value; the new value appears next cycle.
   - rst with upd_en = 1: no table or counter change, mispredict = 0, all entries invalid afterwards.
